// File: rtl/approx_mul_engine.sv
// approx_mul_engine: streams operand pairs from an input RAM, multiplies each
// pair through K-bit leading-one windows and writes the rescaled products to
// an output RAM, one result per enabled cycle.
// Optional feature: define APPROX_BIAS_EN to force the LSB of every shifted
// window to 1 (mean-error compensation). Undefined gives pure truncation.

// Per-operand separation: leading-one detect, window extraction, shift amount.
module approx_mul_sep #(
  parameter int IN_W = 16,
  parameter int K    = 8,
  parameter int SH_W = 5
) (
  input  logic [IN_W-1:0] x,
  output logic [K-1:0]    win,
  output logic [SH_W-1:0] sh
);
  logic [SH_W-1:0] p;

  // Highest set bit wins because the scan runs upward; x=0 leaves p=0.
  always_comb begin
    p = '0;
    for (int i = 0; i < IN_W; i++)
      if (x[i]) p = SH_W'(i);
    sh = '0;
    if (p >= SH_W'(K)) sh = p - SH_W'(K - 1);
    win = K'(x >> sh);
`ifdef APPROX_BIAS_EN
    if (sh != '0) win[0] = 1'b1;
`endif
  end
endmodule

module approx_mul_engine #(
  parameter int IN_W   = 16,
  parameter int K      = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] base_o,
  input  logic [ADDR_W:0]   count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [IN_W-1:0]   rd_data1,
  input  logic [IN_W-1:0]   rd_data2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2*IN_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);
  localparam int SH_W = $clog2(IN_W + 1);
  localparam int P_W  = 2 * IN_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]          remain_q, remain_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  // [0] read issued (RAM data valid next cycle), [1] S1 regs valid, [2] write
  logic [2:0]               vld_pipe_q, vld_pipe_d;
  logic [1:0][K-1:0]        win_q, win_d;
  logic [1:0][SH_W-1:0]     sh_q, sh_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [P_W-1:0]           wr_data_q, wr_data_d;
  logic                     done_q, done_d;

  logic [1:0][IN_W-1:0]     ops;
  logic [1:0][K-1:0]        win_c;
  logic [1:0][SH_W-1:0]     sh_c;
  logic [2*K-1:0]           prod;
  logic [SH_W:0]            sh_sum;
  logic [P_W-1:0]           merged;

  assign ops = {rd_data2, rd_data1};

  // S1: one separator per operand, fed straight from the RAM read port.
  for (genvar g = 0; g < 2; g++) begin : g_sep
    approx_mul_sep #(.IN_W(IN_W), .K(K), .SH_W(SH_W)) u_sep (
      .x   (ops[g]),
      .win (win_c[g]),
      .sh  (sh_c[g])
    );
  end

  // S2 multiply and S3 merge share the cycle that loads the output registers,
  // which keeps read-to-write latency at three enabled cycles.
  always_comb begin
    prod   = (2*K)'(win_q[0]) * (2*K)'(win_q[1]);
    sh_sum = (SH_W+1)'(sh_q[0]) + (SH_W+1)'(sh_q[1]);
    merged = P_W'(prod) << sh_sum;
  end

  // Next-state: sequencing FSM plus pipeline advance; en=0 holds everything.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    remain_d   = remain_q;
    wr_ptr_d   = wr_ptr_q;
    vld_pipe_d = vld_pipe_q;
    win_d      = win_q;
    sh_d       = sh_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    rd_en      = 1'b0;
    if (en) begin
      vld_pipe_d[0] = (state_q == ISSUE);
      vld_pipe_d[1] = vld_pipe_q[0];
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[0]) begin
        win_d = win_c;
        sh_d  = sh_c;
      end
      if (vld_pipe_q[1]) begin
        wr_data_d = merged;
        wr_addr_d = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
      end
      done_d = (state_q == FINISH);
      case (state_q)
        IDLE: begin
          // done_q blocks a start in the done cycle itself
          if (start && !done_q) begin
            rd_addr_d = base_i;
            wr_ptr_d  = base_o;
            remain_d  = count;
            state_d   = (count == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          rd_en     = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          remain_d  = remain_q - (ADDR_W+1)'(1);
          if (remain_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
        DRAIN: begin
          // last pair is in S1 or later; it reaches the outputs this edge
          if (!vld_pipe_q[0]) state_d = FINISH;
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with asynchronous clear that abandons any block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      remain_q   <= '0;
      wr_ptr_q   <= '0;
      vld_pipe_q <= '0;
      win_q      <= '0;
      sh_q       <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      remain_q   <= remain_d;
      wr_ptr_q   <= wr_ptr_d;
      vld_pipe_q <= vld_pipe_d;
      win_q      <= win_d;
      sh_q       <= sh_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_en   = vld_pipe_q[2] & en;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q & en;
endmodule

// File: tb/tb_approx_mul_engine.sv
// Directed bench for approx_mul_engine with a behavioural input RAM and a
// negedge write/done logger.
module tb_approx_mul_engine;
  localparam int IN_W = 16, K = 8, ADDR_W = 5, D = 32;

  logic              clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] base_i = '0, base_o = '0;
  logic [ADDR_W:0]   count = '0;
  logic              rd_en, wr_en, busy, done;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [IN_W-1:0]   rd_data1 = '0, rd_data2 = '0;
  logic [2*IN_W-1:0] wr_data;

  approx_mul_engine #(.IN_W(IN_W), .K(K), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .base_i(base_i), .base_o(base_o), .count(count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [IN_W-1:0] mem1 [D];
  logic [IN_W-1:0] mem2 [D];
  always @(posedge clk) if (rd_en) begin
    rd_data1 <= mem1[rd_addr];
    rd_data2 <= mem2[rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_a[$], rd_c[$], wr_a[$], wr_c[$];
  logic [31:0] wr_d[$];
  int done_n = 0, done_cyc = 0;
  logic busy_at_done = 1'b0;
  always @(negedge clk) begin
    if (rd_en) begin rd_a.push_back(int'(rd_addr)); rd_c.push_back(cyc); end
    if (wr_en) begin wr_a.push_back(int'(wr_addr)); wr_d.push_back(wr_data); wr_c.push_back(cyc); end
    if (done) begin done_n <= done_n + 1; done_cyc <= cyc; busy_at_done <= busy; end
  end

  int n_cmp = 0, n_bad = 0;
  int acc = 0, dn0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_blk(input int bi, input int bo, input int cnt);
    @(negedge clk); #1;
    rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
    dn0 = done_n;
    base_i = ADDR_W'(bi); base_o = ADDR_W'(bo); count = (ADDR_W+1)'(cnt);
    start = 1'b1; acc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_n == dn0 && k < budget) begin @(negedge clk); #1; k++; end
    chk("done_seen", done_n - dn0, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  logic [31:0] e1 [4];

  initial begin
    e1[0] = 32'd15;
`ifdef APPROX_BIAS_EN
    e1[1] = 32'h0012_4440;
`else
    e1[1] = 32'h0012_2000;
`endif
    e1[2] = 32'h0;
    e1[3] = 32'hFE01_0000;
    for (int i = 0; i < D; i++) begin mem1[i] = '0; mem2[i] = '0; end
    mem1[0] = 16'd3;    mem2[0] = 16'd5;
    mem1[1] = 16'h1234; mem2[1] = 16'h0100;
    mem1[2] = 16'h0000; mem2[2] = 16'hFFFF;
    mem1[3] = 16'hFFFF; mem2[3] = 16'hFFFF;

    // reset state
    en = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk_reset_outs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed operands: exact, truncation, zero, max
    start_blk(0, 8, 4);
    wait_done(60);
    chk("t1_nwr", wr_a.size(), 4);
    chk("t1_nrd", rd_a.size(), 4);
    if (wr_a.size() == 4 && rd_a.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t1_addr%0d", i), wr_a[i], 8 + i);
        chk($sformatf("t1_data%0d", i), wr_d[i], e1[i]);
      end
      chk("t1_first_rd", rd_c[0], acc + 1);
      chk("t1_latency", wr_c[0] - rd_c[0], 3);
      chk("t1_done_after_last", done_cyc, wr_c[3] + 1);
    end
    chk("t1_busy_at_done", busy_at_done, 0);

    for (int i = 0; i < D; i++) begin mem1[i] = 16'(i + 1); mem2[i] = 16'(i + 2); end

    // full burst with address wrap on both sides
    start_blk(30, 4, 32);
    wait_done(120);
    chk("burst_nwr", wr_a.size(), 32);
    chk("burst_nrd", rd_a.size(), 32);
    if (wr_a.size() == 32 && rd_a.size() == 32) begin
      for (int j = 0; j < 32; j++) begin
        int a;
        a = (30 + j) % 32;
        chk($sformatf("burst_rd%0d", j), rd_a[j], a);
        chk($sformatf("burst_wa%0d", j), wr_a[j], (4 + j) % 32);
        chk($sformatf("burst_wd%0d", j), wr_d[j], (a + 1) * (a + 2));
      end
      chk("burst_contig", wr_c[31] - wr_c[0], 31);
      chk("burst_done", done_cyc, wr_c[31] + 1);
    end

    // enable stall mid-burst
    start_blk(0, 16, 8);
    repeat (3) @(negedge clk);
    #1 en = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); #1;
      chk("stall_wr_en", wr_en, 0);
      chk("stall_rd_en", rd_en, 0);
    end
    chk("stall_busy", busy, 1);
    en = 1'b1;
    wait_done(80);
    chk("stall_nwr", wr_a.size(), 8);
    if (wr_a.size() == 8) begin
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("stall_wa%0d", j), wr_a[j], 16 + j);
        chk($sformatf("stall_wd%0d", j), wr_d[j], (j + 1) * (j + 2));
      end
    end

    // count = 0
    start_blk(3, 3, 0);
    wait_done(20);
    chk("cnt0_done_cyc", done_cyc, acc + 2);
    chk("cnt0_nrd", rd_a.size(), 0);
    chk("cnt0_nwr", wr_a.size(), 0);

    // start while busy is ignored
    start_blk(0, 8, 4);
    @(negedge clk); #1;
    base_o = ADDR_W'(20); count = (ADDR_W+1)'(2); start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(60);
    repeat (10) @(negedge clk);
    #1;
    chk("busy_start_nwr", wr_a.size(), 4);
    chk("busy_start_nrd", rd_a.size(), 4);
    chk("busy_start_ndone", done_n - dn0, 1);
    if (wr_a.size() == 4) chk("busy_start_wa0", wr_a[0], 8);

    // reset mid-block after 10 writes
    start_blk(0, 0, 32);
    begin
      int k = 0;
      while (wr_a.size() < 10 && k < 100) begin @(negedge clk); #1; k++; end
    end
    chk("rst_reached10", wr_a.size(), 10);
    rst_n = 1'b0;
    #1 chk_reset_outs("rst_mid");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("rst_no_more_wr", wr_a.size(), 10);
    chk("rst_no_done", done_n - dn0, 0);

    // clean run after reset
    start_blk(5, 0, 2);
    wait_done(40);
    chk("post_nwr", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      chk("post_wa0", wr_a[0], 0);
      chk("post_wd0", wr_d[0], 42);
      chk("post_wa1", wr_a[1], 1);
      chk("post_wd1", wr_d[1], 56);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
